// File: rtl/arb_pkg.sv
// Shared arbitration types and width helpers, reused by the bank-group and channel arbiters.
package arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StDrain
    } arb_state_e;

    // Index width that never collapses to zero for a single-entry vector.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DefaultNumBanks = 4;
    localparam int unsigned DefaultSelW     = idx_w(DefaultNumBanks);

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of req at or after ptr, wrapping modulo NUM_BANKS.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned NUM_BANKS = DefaultNumBanks,
    parameter int unsigned SEL_W     = idx_w(NUM_BANKS)
) (
    input  logic [NUM_BANKS-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic [SEL_W-1:0]     idx,
    output logic                 found
);

    logic [NUM_BANKS-1:0] rot;
    logic [SEL_W-1:0]     off;

    always_comb begin
        // Rotate so that bit 0 of rot is the bank at ptr.
        rot = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            rot[i] = req[SEL_W'((32'(ptr) + i) % NUM_BANKS)];
        end

        off = '0;
        for (int i = int'(NUM_BANKS) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end

        // Un-rotate; the modulo keeps non-power-of-two groups from wrapping at 2^SEL_W.
        idx   = SEL_W'((32'(off) + 32'(ptr)) % NUM_BANKS);
        found = |req;
    end

endmodule

// File: rtl/bank_group_rr_arbiter.sv
// Bank-group arbiter: round-robin grant, burst-capped drain of one bank at a time.
module bank_group_rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_BANKS = DefaultNumBanks,
    parameter int unsigned SEL_W     = $clog2(NUM_BANKS),
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_BANKS-1:0] bank_req,
    input  logic [NUM_BANKS-1:0] bank_valid,
    output logic [NUM_BANKS-1:0] ack,
    output logic [SEL_W-1:0]     sel,
    output logic                 en,
    output logic                 done,
    output logic                 req,
    output logic                 busy
);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] cur_q, cur_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic [SEL_W-1:0] cur_inc;
    logic [SEL_W-1:0] idle_idx, ho_idx;
    logic             idle_found, ho_found;
    logic             drain_more;

    assign cur_inc = (cur_q == SEL_W'(NUM_BANKS - 1)) ? '0 : cur_q + 1'b1;

    rr_pick #(
        .NUM_BANKS(NUM_BANKS),
        .SEL_W    (SEL_W)
    ) u_pick_idle (
        .req  (bank_req),
        .ptr  (rr_ptr_q),
        .idx  (idle_idx),
        .found(idle_found)
    );

    // Handover search starts just past the bank being released, so it goes last.
    rr_pick #(
        .NUM_BANKS(NUM_BANKS),
        .SEL_W    (SEL_W)
    ) u_pick_handover (
        .req  (bank_req),
        .ptr  (cur_inc),
        .idx  (ho_idx),
        .found(ho_found)
    );

    assign drain_more = bank_req[cur_q] & bank_valid[cur_q]
                      & (burst_cnt_q < CNT_W'(MAX_BURST));

    assign req  = |bank_req;
    assign busy = rst_n & (state_q == StDrain);

    always_comb begin
        ack         = '0;
        sel         = '0;
        en          = 1'b0;
        done        = 1'b0;
        state_d     = state_q;
        cur_d       = cur_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;

        if (rst_n && start) begin
            unique case (state_q)
                StIdle: begin
                    if (idle_found) begin
                        ack[idle_idx] = 1'b1;
                        en            = 1'b1;
                        sel           = idle_idx;
                        cur_d         = idle_idx;
                        burst_cnt_d   = CNT_W'(1);
                        state_d       = StDrain;
                    end
                end
                StDrain: begin
                    if (drain_more) begin
                        en          = 1'b1;
                        sel         = cur_q;
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end else begin
                        done     = 1'b1;
                        rr_ptr_d = cur_inc;
                        if (ho_found) begin
                            // Bubble cycle: grant only, the new bank drains from next cycle.
                            ack[ho_idx] = 1'b1;
                            sel         = ho_idx;
                            cur_d       = ho_idx;
                            burst_cnt_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifndef SYNTHESIS
    ack_onehot0_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));
    en_valid_a:    assert property (@(posedge clk) disable iff (!rst_n) en |-> bank_valid[sel]);
    done_no_en_a:  assert property (@(posedge clk) disable iff (!rst_n) done |-> !en);
    cnt_cap_a:     assert property (@(posedge clk) disable iff (!rst_n)
                                    burst_cnt_q <= CNT_W'(MAX_BURST));
`endif

endmodule

// File: tb/tb_bank_group_rr_arbiter.sv
// Directed scoreboard bench over four arbiter configurations sharing one clock and reset.
module tb_bank_group_rr_arbiter;

    logic clk;
    logic rst_n;
    logic start;

    // a: 4 banks, burst 8   b: 4 banks, burst 4   c: 4 banks, burst 2   d: 5 banks, burst 2
    logic [3:0] req_a, val_a, ack_a;
    logic [1:0] sel_a;
    logic       en_a, done_a, busy_a, rq_a;
    logic [3:0] req_b, val_b, ack_b;
    logic [1:0] sel_b;
    logic       en_b, done_b, busy_b, rq_b;
    logic [3:0] req_c, val_c, ack_c;
    logic [1:0] sel_c;
    logic       en_c, done_c, busy_c, rq_c;
    logic [4:0] req_d, val_d, ack_d;
    logic [2:0] sel_d;
    logic       en_d, done_d, busy_d, rq_d;

    bank_group_rr_arbiter #(.NUM_BANKS(4), .MAX_BURST(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .bank_req(req_a), .bank_valid(val_a),
        .ack(ack_a), .sel(sel_a), .en(en_a), .done(done_a), .req(rq_a), .busy(busy_a)
    );
    bank_group_rr_arbiter #(.NUM_BANKS(4), .MAX_BURST(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .bank_req(req_b), .bank_valid(val_b),
        .ack(ack_b), .sel(sel_b), .en(en_b), .done(done_b), .req(rq_b), .busy(busy_b)
    );
    bank_group_rr_arbiter #(.NUM_BANKS(4), .MAX_BURST(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .bank_req(req_c), .bank_valid(val_c),
        .ack(ack_c), .sel(sel_c), .en(en_c), .done(done_c), .req(rq_c), .busy(busy_c)
    );
    bank_group_rr_arbiter #(.NUM_BANKS(5), .MAX_BURST(2)) u_dut_d (
        .clk(clk), .rst_n(rst_n), .start(start), .bank_req(req_d), .bank_valid(val_d),
        .ack(ack_d), .sel(sel_d), .en(en_d), .done(done_d), .req(rq_d), .busy(busy_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          inst;
        logic [11:0] exp;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    // Packed as {ack[4:0], sel[2:0], en, done, busy, req}.
    function automatic logic [11:0] observe(input int inst);
        case (inst)
            0:       return {1'b0, ack_a, 1'b0, sel_a, en_a, done_a, busy_a, rq_a};
            1:       return {1'b0, ack_b, 1'b0, sel_b, en_b, done_b, busy_b, rq_b};
            2:       return {1'b0, ack_c, 1'b0, sel_c, en_c, done_c, busy_c, rq_c};
            default: return {ack_d, sel_d, en_d, done_d, busy_d, rq_d};
        endcase
    endfunction

    // Inputs are already applied at a negedge; check after settling, then advance one cycle.
    task automatic cyc(input string tag, input int inst, input logic [4:0] e_ack,
                       input logic [2:0] e_sel, input logic e_en, input logic e_done,
                       input logic e_busy, input logic e_req);
        sb_t         got;
        logic [11:0] obs;
        sb.push_back('{tag, inst, {e_ack, e_sel, e_en, e_done, e_busy, e_req}});
        #1;
        got = sb.pop_front();
        obs = observe(got.inst);
        checks++;
        assert (obs === got.exp) else begin
            errors++;
            $error("FAIL %s: observed ack/sel/en/done/busy/req=%h expected %h",
                   got.tag, obs, got.exp);
        end
        @(negedge clk);
    endtask

    initial begin
        int b;
        clk   = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        {req_a, val_a, req_b, val_b, req_c, val_c} = '0;
        req_d = '0;
        val_d = '0;
        repeat (2) @(negedge clk);

        // Reset holds every output low except req.
        start = 1'b1; req_a = 4'b0001; val_a = 4'b0001;
        cyc("reset_out", 0, 5'b0, 3'd0, 0, 0, 0, 1);
        rst_n = 1'b1; req_a = '0; val_a = '0;

        // Single bank 2: same-cycle grant, three beats, done when req drops.
        req_a = 4'b0100; val_a = 4'b0100;
        cyc("t1_grant", 0, 5'b00100, 3'd2, 1, 0, 0, 1);
        repeat (2) cyc("t1_en", 0, 5'b0, 3'd2, 1, 0, 1, 1);
        req_a = '0; val_a = '0;
        cyc("t1_done", 0, 5'b0, 3'd0, 0, 1, 1, 0);
        cyc("t1_idle", 0, 5'b0, 3'd0, 0, 0, 0, 0);

        // Freeze on bank 3 after two beats; resume must finish exactly at the cap of 8.
        req_a = 4'b1000; val_a = 4'b1000;
        cyc("frz_grant", 0, 5'b01000, 3'd3, 1, 0, 0, 1);
        cyc("frz_en", 0, 5'b0, 3'd3, 1, 0, 1, 1);
        start = 1'b0;
        repeat (5) cyc("frz_hold", 0, 5'b0, 3'd0, 0, 0, 1, 1);
        start = 1'b1;
        repeat (6) cyc("frz_resume", 0, 5'b0, 3'd3, 1, 0, 1, 1);
        cyc("frz_cap", 0, 5'b01000, 3'd3, 0, 1, 1, 1);
        req_a = '0; val_a = '0;
        cyc("frz_done", 0, 5'b0, 3'd0, 0, 1, 1, 0);
        cyc("frz_idle", 0, 5'b0, 3'd0, 0, 0, 0, 0);

        // Move rr_ptr to 2, reset mid-burst on bank 1, then confirm the pointer restarts at 0.
        req_a = 4'b0010; val_a = 4'b0010;
        cyc("rst_pre_grant", 0, 5'b00010, 3'd1, 1, 0, 0, 1);
        req_a = '0; val_a = '0;
        cyc("rst_pre_done", 0, 5'b0, 3'd0, 0, 1, 1, 0);
        req_a = 4'b0010; val_a = 4'b0010;
        cyc("rst_grant", 0, 5'b00010, 3'd1, 1, 0, 0, 1);
        cyc("rst_en", 0, 5'b0, 3'd1, 1, 0, 1, 1);
        rst_n = 1'b0;
        cyc("rst_active", 0, 5'b0, 3'd0, 0, 0, 0, 1);
        rst_n = 1'b1; start = 1'b0;
        cyc("rst_after_idle", 0, 5'b0, 3'd0, 0, 0, 0, 1);
        start = 1'b1; req_a = 4'b0110; val_a = 4'b0110;
        cyc("rst_ptr_zero", 0, 5'b00010, 3'd1, 1, 0, 0, 1);
        req_a = '0; val_a = '0;
        cyc("rst_end", 0, 5'b0, 3'd0, 0, 1, 1, 0);

        // Burst cap 4 with banks 0 and 1 always valid.
        req_b = 4'b0011; val_b = 4'b0011;
        cyc("cap_grant", 1, 5'b00001, 3'd0, 1, 0, 0, 1);
        repeat (3) cyc("cap_en", 1, 5'b0, 3'd0, 1, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            b = (k + 1) % 2;
            cyc("cap_handover", 1, 5'(1 << b), 3'(b), 0, 1, 1, 1);
            repeat (4) cyc("cap_en", 1, 5'b0, 3'(b), 1, 0, 1, 1);
        end
        req_b = '0; val_b = '0;
        cyc("cap_done", 1, 5'b0, 3'd0, 0, 1, 1, 0);
        cyc("cap_idle", 1, 5'b0, 3'd0, 0, 0, 0, 0);

        // Fairness: four requesters, burst 2, grant order 0,1,2,3,0,1.
        req_c = 4'hF; val_c = 4'hF;
        cyc("fair_grant", 2, 5'b00001, 3'd0, 1, 0, 0, 1);
        cyc("fair_en", 2, 5'b0, 3'd0, 1, 0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            b = (k + 1) % 4;
            cyc("fair_handover", 2, 5'(1 << b), 3'(b), 0, 1, 1, 1);
            repeat (2) cyc("fair_en", 2, 5'b0, 3'(b), 1, 0, 1, 1);
        end
        req_c = '0; val_c = '0;
        cyc("fair_done", 2, 5'b0, 3'd0, 0, 1, 1, 0);
        cyc("fair_idle", 2, 5'b0, 3'd0, 0, 0, 0, 0);

        // Five banks, only 4 and 0 requesting: handover from 4 must wrap to 0.
        req_d = 5'b10001; val_d = 5'b10001;
        cyc("nb5_grant", 3, 5'b00001, 3'd0, 1, 0, 0, 1);
        cyc("nb5_en", 3, 5'b0, 3'd0, 1, 0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            b = (k % 2 == 0) ? 4 : 0;
            cyc("nb5_handover", 3, 5'(1 << b), 3'(b), 0, 1, 1, 1);
            repeat (2) cyc("nb5_en", 3, 5'b0, 3'(b), 1, 0, 1, 1);
        end
        req_d = '0; val_d = '0;
        cyc("nb5_done", 3, 5'b0, 3'd0, 0, 1, 1, 0);
        cyc("nb5_idle", 3, 5'b0, 3'd0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
